// File: rtl/multiexp_pnt_scl_sched_pkg.sv
// Shared types and constants for the point/scalar replay scheduler.
// Holds the scheduler FSM state type, the bit offsets of the fields inside the
// output ctl word, default point/scalar widths and a small width helper.
// Optional feature macro used by the scheduler: MULTIEXP_ZERO_SKIP_EN.
package multiexp_pnt_scl_sched_pkg;

  // Defaults sized for an fp2 Jacobian point and a 256-bit field element.
  localparam int unsigned DEF_PNT_BITS = 1536;
  localparam int unsigned DEF_SCL_BITS = 256;

  // Field offsets inside o_pnt_if.ctl.
  localparam int unsigned CTL_BIT_LSB  = 0;
  localparam int unsigned CTL_CORE_LSB = 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReplay
  } sched_state_t;

  // $clog2 that never returns 0, so derived vectors stay at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/multiexp_pnt_scl_sched_if.sv
// Valid/ready stream bundle used for both the pair input and the point output.
// Ports (signals):
//   val  - beat valid (master)
//   rdy  - beat ready (slave)
//   sop  - first beat of a packet (master)
//   eop  - last beat of a packet (master)
//   dat  - payload, DAT_BITS wide (master)
//   ctl  - side-band control, CTL_BITS wide (master)
interface multiexp_pnt_scl_sched_if #(
  parameter int unsigned DAT_BITS = 8,
  parameter int unsigned CTL_BITS = 1
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport master (output val, sop, eop, dat, ctl, input rdy);
  modport slave  (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_sched_ram.sv
// Simple dual-port RAM holding the loaded {point, scalar} pairs.
// Ports:
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_re    - read enable
//   i_raddr - read address
//   o_rdata - read data, registered (valid one cycle after i_re)
// Contents are not reset.
module multiexp_pnt_scl_sched_ram #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]     i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WIDTH-1:0]     o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/multiexp_pnt_scl_sched.sv
// Point/scalar replay scheduler. Loads up to MAX_IN {point, scalar} pairs into
// RAM, then replays every stored point SCL_BITS times (MSB pass first), tagging
// each beat with the scalar bit of the current pass and a core index.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_num_in      - pair count, sampled with the first accepted beat in idle
//   i_pnt_scl_if  - pair input stream, dat = {point, scalar}
//   o_pnt_if      - point output stream, ctl = {core, scalar bit}, sop/eop per pass
//   o_pass        - scalar bit index of the beat on o_pnt_if
//   o_done        - one-cycle pulse when a job completes
//   o_err         - sticky, pair count above MAX_IN was seen
// Macro: MULTIEXP_ZERO_SKIP_EN - pairs with an all-zero scalar are not stored.
module multiexp_pnt_scl_sched
  import multiexp_pnt_scl_sched_pkg::*;
#(
  parameter int unsigned PNT_BITS  = DEF_PNT_BITS,
  parameter int unsigned SCL_BITS  = DEF_SCL_BITS,
  parameter int unsigned MAX_IN    = 1024,
  parameter int unsigned NUM_CORES = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [63:0]                 i_num_in,
  multiexp_pnt_scl_sched_if.slave     i_pnt_scl_if,
  multiexp_pnt_scl_sched_if.master    o_pnt_if,
  output logic [$clog2(SCL_BITS)-1:0] o_pass,
  output logic                        o_done,
  output logic                        o_err
);
  localparam int unsigned AW     = clog2_min1(MAX_IN);
  localparam int unsigned CNT_W  = $clog2(MAX_IN + 1);
  localparam int unsigned PASS_W = $clog2(SCL_BITS);
  localparam int unsigned CORE_W = clog2_min1(NUM_CORES);
  // Packed beat layout: {pass, sop, eop, core, bit, point}.
  localparam int unsigned B_BIT  = PNT_BITS;
  localparam int unsigned B_CORE = B_BIT + 1;
  localparam int unsigned B_EOP  = B_CORE + CORE_W;
  localparam int unsigned B_SOP  = B_EOP + 1;
  localparam int unsigned B_PASS = B_SOP + 1;
  localparam int unsigned BEAT_W = B_PASS + PASS_W;

  sched_state_t r_state;
  logic r_in_rdy, r_done, r_err;
  logic [CNT_W-1:0] r_num_in, r_cnt_in, r_num_st;

  logic w_in_fire, w_store, w_take, w_last_in, w_load_done, w_all_zero, w_final;
  logic w_num_ok, w_num_zero, w_pop, w_issue, w_rd_last;
  logic [CNT_W-1:0] w_num_st_nxt;
  logic [AW-1:0] w_waddr;
  logic [PNT_BITS+SCL_BITS-1:0] w_ram_rdata;
  logic [SCL_BITS-1:0] w_ram_scl;
  logic [BEAT_W-1:0] w_ram_beat;
  logic [1:0] w_occ;
  logic w_unused;

  assign w_unused   = ^{i_pnt_scl_if.sop, i_pnt_scl_if.eop, i_pnt_scl_if.ctl};
  assign w_in_fire  = i_pnt_scl_if.val & r_in_rdy;
  assign w_num_ok   = i_num_in <= 64'(MAX_IN);
  assign w_num_zero = i_num_in == 64'd0;
`ifdef MULTIEXP_ZERO_SKIP_EN
  assign w_store = |i_pnt_scl_if.dat[SCL_BITS-1:0];
`else
  assign w_store = 1'b1;
`endif
  // A beat that belongs to a valid job (first beat in idle or any beat in load).
  assign w_take = w_in_fire & (((r_state == StIdle) & w_num_ok & ~w_num_zero) |
                               (r_state == StLoad));
  assign w_last_in = (r_state == StIdle) ? (i_num_in == 64'd1)
                                         : (r_cnt_in == r_num_in - CNT_W'(1));
  assign w_num_st_nxt = ((r_state == StIdle) ? '0 : r_num_st) + CNT_W'(w_store);
  assign w_waddr      = (r_state == StIdle) ? '0 : r_num_st[AW-1:0];
  assign w_load_done  = w_take & w_last_in & (w_num_st_nxt != '0);
  assign w_all_zero   = w_take & w_last_in & (w_num_st_nxt == '0);

  // Control FSM: input handshake, job bookkeeping, done/err flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_in_rdy <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_num_in <= '0;
      r_cnt_in <= '0;
      r_num_st <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_in_rdy <= 1'b1;
          if (w_in_fire) begin
            if (!w_num_ok) begin
              r_err <= 1'b1;
            end else if (w_num_zero) begin
              r_done <= 1'b1;
            end else begin
              r_num_in <= CNT_W'(i_num_in);
              r_cnt_in <= CNT_W'(1);
              r_num_st <= w_num_st_nxt;
              if (w_load_done) begin
                r_state  <= StReplay;
                r_in_rdy <= 1'b0;
              end else if (w_all_zero) begin
                r_done <= 1'b1;
              end else begin
                r_state <= StLoad;
              end
            end
          end
        end
        StLoad: begin
          if (w_in_fire) begin
            r_cnt_in <= r_cnt_in + CNT_W'(1);
            r_num_st <= w_num_st_nxt;
            if (w_load_done) begin
              r_state  <= StReplay;
              r_in_rdy <= 1'b0;
            end else if (w_all_zero) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end
          end
        end
        StReplay: begin
          if (w_final) begin
            r_state  <= StIdle;
            r_in_rdy <= 1'b1;
            r_done   <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read side: idx/pass/core counters, one read in flight plus a 2-entry output skid.
  logic                r_rd_active, r_ram_vld, r_ram_sop, r_ram_eop;
  logic [AW-1:0]       r_rd_idx;
  logic [PASS_W-1:0]   r_rd_pass, r_ram_pass;
  logic [CORE_W-1:0]   r_rd_core, r_ram_core;
  logic                r_out_val, r_skid_val;
  logic [BEAT_W-1:0]   r_out_beat, r_skid_beat;

  assign w_pop     = r_out_val & o_pnt_if.rdy;
  // Entries held after this edge (output, skid, landing read); issue only if one is left free.
  assign w_occ     = 2'(r_out_val) + 2'(r_skid_val) + 2'(r_ram_vld) - 2'(w_pop);
  assign w_issue   = r_rd_active & (w_occ <= 2'd1);
  assign w_rd_last = CNT_W'(r_rd_idx) == r_num_st - CNT_W'(1);
  assign w_final   = w_pop & r_out_beat[B_EOP] & (r_out_beat[B_PASS +: PASS_W] == '0);
  assign w_ram_scl = w_ram_rdata[SCL_BITS-1:0];

  always_comb begin
    w_ram_beat                  = '0;
    w_ram_beat[0 +: PNT_BITS]   = w_ram_rdata[SCL_BITS +: PNT_BITS];
    w_ram_beat[B_BIT]           = w_ram_scl[r_ram_pass];
    w_ram_beat[B_CORE +: CORE_W] = r_ram_core;
    w_ram_beat[B_EOP]           = r_ram_eop;
    w_ram_beat[B_SOP]           = r_ram_sop;
    w_ram_beat[B_PASS +: PASS_W] = r_ram_pass;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_active <= 1'b0;
      r_rd_idx    <= '0;
      r_rd_pass   <= '0;
      r_rd_core   <= '0;
      r_ram_vld   <= 1'b0;
      r_ram_sop   <= 1'b0;
      r_ram_eop   <= 1'b0;
      r_ram_core  <= '0;
      r_ram_pass  <= '0;
    end else begin
      r_ram_vld <= w_issue;
      if (w_issue) begin
        r_ram_sop  <= r_rd_idx == '0;
        r_ram_eop  <= w_rd_last;
        r_ram_core <= r_rd_core;
        r_ram_pass <= r_rd_pass;
      end
      if (w_load_done) begin
        r_rd_active <= 1'b1;
        r_rd_idx    <= '0;
        r_rd_pass   <= PASS_W'(SCL_BITS - 1);
        r_rd_core   <= '0;
      end else if (w_issue) begin
        if (w_rd_last) begin
          r_rd_idx  <= '0;
          r_rd_core <= '0;
          if (r_rd_pass == '0) r_rd_active <= 1'b0;
          else                 r_rd_pass   <= r_rd_pass - PASS_W'(1);
        end else begin
          r_rd_idx  <= r_rd_idx + AW'(1);
          r_rd_core <= (r_rd_core == CORE_W'(NUM_CORES - 1)) ? '0 : r_rd_core + CORE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_val   <= 1'b0;
      r_out_beat  <= '0;
      r_skid_val  <= 1'b0;
      r_skid_beat <= '0;
    end else if (!r_out_val || w_pop) begin
      if (r_skid_val) begin
        r_out_val  <= 1'b1;
        r_out_beat <= r_skid_beat;
        r_skid_val <= r_ram_vld;
        if (r_ram_vld) r_skid_beat <= w_ram_beat;
      end else begin
        r_out_val <= r_ram_vld;
        if (r_ram_vld) r_out_beat <= w_ram_beat;
      end
    end else if (r_ram_vld) begin
      r_skid_val  <= 1'b1;
      r_skid_beat <= w_ram_beat;
    end
  end

  multiexp_pnt_scl_sched_ram #(
    .WIDTH     (PNT_BITS + SCL_BITS),
    .DEPTH     (MAX_IN),
    .ADDR_BITS (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_take & w_store),
    .i_waddr (w_waddr),
    .i_wdata (i_pnt_scl_if.dat[PNT_BITS+SCL_BITS-1:0]),
    .i_re    (w_issue),
    .i_raddr (r_rd_idx),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    o_pnt_if.ctl                         = '0;
    o_pnt_if.ctl[CTL_BIT_LSB]            = r_out_beat[B_BIT];
    o_pnt_if.ctl[CTL_CORE_LSB +: CORE_W] = r_out_beat[B_CORE +: CORE_W];
  end

  assign i_pnt_scl_if.rdy = r_in_rdy;
  assign o_pnt_if.val     = r_out_val;
  assign o_pnt_if.dat     = r_out_beat[0 +: PNT_BITS];
  assign o_pnt_if.sop     = r_out_beat[B_SOP];
  assign o_pnt_if.eop     = r_out_beat[B_EOP];
  assign o_pass           = r_out_beat[B_PASS +: PASS_W];
  assign o_done           = r_done;
  assign o_err            = r_err;
endmodule

// File: tb/tb_multiexp_pnt_scl_sched.sv
// Self-checking bench for multiexp_pnt_scl_sched (small configuration:
// 16-bit points, 8-bit scalars, 16-pair RAM, 8 cores). Expected beats are
// pushed to a scoreboard queue when a job is loaded and popped by the output
// monitor. Honours MULTIEXP_ZERO_SKIP_EN in its reference model.
module tb_multiexp_pnt_scl_sched;
  localparam int unsigned PB = 16;
  localparam int unsigned SB = 8;
  localparam int unsigned MI = 16;
  localparam int unsigned NC = 8;
`ifdef MULTIEXP_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  typedef struct {
    logic [15:0] dat;
    logic        bitv;
    logic [2:0]  core;
    logic        sop;
    logic        eop;
    logic [2:0]  pass;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] num_in;
  logic [2:0]  o_pass;
  logic        o_done;
  logic        o_err;

  multiexp_pnt_scl_sched_if #(.DAT_BITS(PB + SB), .CTL_BITS(1)) in_if ();
  multiexp_pnt_scl_sched_if #(.DAT_BITS(PB), .CTL_BITS(4)) out_if ();

  multiexp_pnt_scl_sched #(
    .PNT_BITS  (PB),
    .SCL_BITS  (SB),
    .MAX_IN    (MI),
    .NUM_CORES (NC)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_num_in     (num_in),
    .i_pnt_scl_if (in_if),
    .o_pnt_if     (out_if),
    .o_pass       (o_pass),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  int   n_checks = 0;
  int   n_errs   = 0;
  int   n_done   = 0;
  int   n_beats  = 0;
  bit   rnd_rdy  = 1'b0;
  exp_t sb[$];
  logic [15:0] t_pnt [16];
  logic [7:0]  t_scl [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output ready: either held high or toggled randomly after each rising edge.
  initial begin
    out_if.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: samples on the falling edge, where all signals are stable.
  initial begin
    bit          held;
    bit          exp_done;
    logic [24:0] cur;
    logic [24:0] held_beat;
    exp_t        e;
    held = 1'b0;
    exp_done = 1'b0;
    held_beat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        exp_done = 1'b0;
        continue;
      end
      cur = {out_if.sop, out_if.eop, o_pass, out_if.ctl, out_if.dat};
      if (exp_done) begin
        check_eq("done_after_last_beat", o_done, 1);
        exp_done = 1'b0;
      end
      if (o_done) n_done++;
      if (held) check_eq("hold_stable", {out_if.val, cur}, {1'b1, held_beat});
      held = out_if.val && !out_if.rdy;
      held_beat = cur;
      if (out_if.val && out_if.rdy) begin
        n_beats++;
        if (sb.size() == 0) begin
          check_eq("extra_beat", {out_if.val, cur}, 0);
        end else begin
          e = sb.pop_front();
          check_eq("beat_dat", out_if.dat, e.dat);
          check_eq("beat_ctl", out_if.ctl, {e.core, e.bitv});
          check_eq("beat_sop_eop_pass", {out_if.sop, out_if.eop, o_pass}, {e.sop, e.eop, e.pass});
          if (e.eop && e.pass == 3'd0) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] num, input logic [15:0] p, input logic [7:0] s);
    int t;
    t = 0;
    @(negedge clk);
    num_in = num;
    in_if.val = 1'b1;
    in_if.dat = {p, s};
    while (in_if.rdy !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check_eq("in_rdy_timeout", in_if.rdy, 1);
    @(posedge clk);
    #1;
    in_if.val = 1'b0;
  endtask

  // Builds the expected replay of t_pnt/t_scl[0..n-1], then streams the pairs in.
  task automatic load_set(input int n);
    int st[$];
    for (int i = 0; i < n; i++)
      if (!(ZSKIP && t_scl[i] == 8'd0)) st.push_back(i);
    for (int p = SB - 1; p >= 0; p--) begin
      for (int k = 0; k < st.size(); k++) begin
        exp_t e;
        e.dat  = t_pnt[st[k]];
        e.bitv = t_scl[st[k]][3'(p)];
        e.core = 3'(k % NC);
        e.sop  = (k == 0);
        e.eop  = (k == st.size() - 1);
        e.pass = 3'(p);
        sb.push_back(e);
      end
    end
    for (int i = 0; i < n; i++) send_beat(64'(n), t_pnt[i], t_scl[i]);
  endtask

  task automatic wait_drain(input int d0);
    int t;
    t = 0;
    while ((sb.size() != 0 || n_done == d0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
    check_eq("done_count", n_done, d0 + 1);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      t_pnt[i] = 16'($urandom);
      t_scl[i] = 8'($urandom_range(1, 255));
    end
  endtask

  initial begin
    int d0;
    int nb;
    int t;
    rst = 1'b1;
    num_in = '0;
    in_if.val = 1'b0;
    in_if.dat = '0;
    in_if.sop = 1'b0;
    in_if.eop = 1'b0;
    in_if.ctl = '0;
    #3;
    check_eq("reset_outputs",
             {out_if.val, out_if.sop, out_if.eop, out_if.ctl, out_if.dat, o_pass, o_done, o_err,
              in_if.rdy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_rdy", in_if.rdy, 1);

    // Fixed pattern, N=4, with first-valid latency.
    t_pnt[0] = 16'hA000; t_pnt[1] = 16'hA111; t_pnt[2] = 16'hA222; t_pnt[3] = 16'hA333;
    t_scl[0] = 8'h0F;    t_scl[1] = 8'h00;    t_scl[2] = 8'h0A;    t_scl[3] = 8'h05;
    d0 = n_done;
    load_set(4);
    check_eq("rdy_low_in_replay", in_if.rdy, 0);
    repeat (2) @(negedge clk);
    check_eq("first_val_early", out_if.val, 0);
    @(negedge clk);
    check_eq("first_val", out_if.val, 1);
    wait_drain(d0);

    // N=10: core index wraps 0..7,0,1 each pass.
    fill_random(10);
    d0 = n_done;
    load_set(10);
    wait_drain(d0);

    // N=MAX_IN with random output back-pressure.
    fill_random(16);
    rnd_rdy = 1'b1;
    d0 = n_done;
    load_set(16);
    wait_drain(d0);
    rnd_rdy = 1'b0;

    // Count above MAX_IN: sticky error, nothing emitted, input stays ready.
    nb = n_beats;
    d0 = n_done;
    send_beat(64'(MI + 1), 16'h1234, 8'h55);
    check_eq("err_set", o_err, 1);
    repeat (6) @(negedge clk);
    check_eq("err_rdy", in_if.rdy, 1);
    check_eq("err_no_beats", n_beats, nb);
    check_eq("err_no_done", n_done, d0);

    // Count zero: done pulse only.
    send_beat(64'd0, 16'h4321, 8'h11);
    check_eq("zero_done", o_done, 1);
    repeat (6) @(negedge clk);
    check_eq("zero_no_beats", n_beats, nb);
    check_eq("zero_done_count", n_done, d0 + 1);

    // Reset in the middle of a replay, then a fresh small job.
    fill_random(8);
    load_set(8);
    t = 0;
    while (!(out_if.val && o_pass == 3'd5) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_pass5", {out_if.val, o_pass}, {1'b1, 3'd5});
    d0 = n_done;
    #2;
    rst = 1'b1;
    #1;
    check_eq("reset_mid_outputs",
             {out_if.val, out_if.sop, out_if.eop, out_if.ctl, out_if.dat, o_pass, o_done, o_err,
              in_if.rdy}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("no_done_on_reset", n_done, d0);
    fill_random(2);
    load_set(2);
    wait_drain(d0);

    // Zero scalars interleaved (compacted when zero-skip is built in).
    t_pnt[0] = 16'hB000; t_pnt[1] = 16'hB111; t_pnt[2] = 16'hB222; t_pnt[3] = 16'hB333;
    t_scl[0] = 8'h00;    t_scl[1] = 8'h03;    t_scl[2] = 8'h00;    t_scl[3] = 8'h01;
    d0 = n_done;
    load_set(4);
    wait_drain(d0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
